// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader slice.
//   - loaderState_t  : loader FSM state encodings
//   - BYTES_PER_WORD : stream bytes per instruction word
//   - DEFAULT_*      : default widths and word-count limit
//   - lengthInRange(): accepts a session length N when 1 <= N <= maxLen
package program_loader_pkg;

  localparam int BYTES_PER_WORD      = 4;
  localparam int DEFAULT_ADDR_WIDTH  = 16;
  localparam int DEFAULT_INSTR_WIDTH = 28;
  localparam int DEFAULT_MAX_WORDS   = 256;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    CHECK  = 3'd5,
    DONE   = 3'd6,
    ERROR  = 3'd7
  } loaderState_t;

  function automatic logic lengthInRange(input logic [15:0] len, input logic [15:0] maxLen);
    return (len != 16'd0) && (len <= maxLen);
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Handshake and instruction-memory write bus of the program loader.
//   master : stream source / system side (drives iStart, iByte, iByteValid)
//   slave  : the loader (drives ready, write port, cpu reset and status)
interface program_loader_if #(
  parameter int ADDR_WIDTH  = program_loader_pkg::DEFAULT_ADDR_WIDTH,
  parameter int INSTR_WIDTH = program_loader_pkg::DEFAULT_INSTR_WIDTH
) ();

  logic                   iStart;
  logic [7:0]             iByte;
  logic                   iByteValid;
  logic                   oByteReady;
  logic                   oInstrWriteEnable;
  logic [ADDR_WIDTH-1:0]  oInstrAddress;
  logic [INSTR_WIDTH-1:0] oInstrData;
  logic                   oCpuReset;
  logic                   oDone;
  logic                   oError;
  logic [ADDR_WIDTH-1:0]  oWordCount;

  modport master (
    output iStart, iByte, iByteValid,
    input  oByteReady, oInstrWriteEnable, oInstrAddress, oInstrData,
    input  oCpuReset, oDone, oError, oWordCount
  );

  modport slave (
    input  iStart, iByte, iByteValid,
    output oByteReady, oInstrWriteEnable, oInstrAddress, oInstrData,
    output oCpuReset, oDone, oError, oWordCount
  );

endinterface

// File: rtl/program_loader_instr_byte_assembler.sv
// Collects four stream bytes into one big-endian instruction word.
//   Clock, Reset : clock, async active-high reset
//   clear        : restart at byte 0 (new session)
//   byteEn       : a data byte transfers this cycle
//   byteIn       : the data byte
//   wordComplete : this transfer is the 4th byte of a word
//   word         : assembled word including the byte in flight, so the
//                  loader can register it on the same edge
module instr_byte_assembler
  import program_loader_pkg::*;
#(
  parameter int INSTR_WIDTH = DEFAULT_INSTR_WIDTH
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   clear,
  input  logic                   byteEn,
  input  logic [7:0]             byteIn,
  output logic                   wordComplete,
  output logic [INSTR_WIDTH-1:0] word
);

  localparam logic [1:0] LAST_INDEX = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  byteIndex;
  logic [31:0] shiftReg;
  logic [31:0] shiftNext;
  logic        unusedBits;

  assign shiftNext    = {shiftReg[23:0], byteIn};
  assign wordComplete = byteEn && (byteIndex == LAST_INDEX);
  assign word         = shiftNext[INSTR_WIDTH-1:0];

  // The top nibble of b0 and the oldest shifted-out byte never reach the word.
  assign unusedBits = ^{shiftReg[31:24], shiftNext[31:INSTR_WIDTH]};

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      byteIndex <= '0;
      shiftReg  <= '0;
    end else if (clear) begin
      byteIndex <= '0;
      shiftReg  <= '0;
    end else if (byteEn) begin
      byteIndex <= byteIndex + 2'd1;
      shiftReg  <= shiftNext;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Program loader: fills instruction memory from a length-prefixed byte
// stream and holds the core in reset while doing so.
//   Clock, Reset : clock, async active-high reset
//   bus (slave)  : iStart / iByte / iByteValid / oByteReady handshake,
//                  oInstrWriteEnable / oInstrAddress / oInstrData write port,
//                  oCpuReset, oDone, oError, oWordCount status
// Build option: define LOADER_CHECKSUM_EN to require a trailing XOR
// checksum byte over all data bytes before DONE.
//
// state  | meaning
// IDLE   | no session, core released, not ready
// LEN_HI | waiting for high byte of word count N
// LEN_LO | waiting for low byte of N, then range check
// DATA   | collecting the 4 bytes of the next word
// WRITE  | one-cycle instruction memory write
// CHECK  | waiting for checksum byte (checksum build only)
// DONE   | one-cycle done pulse, core released on exit
// ERROR  | sticky failure, core held, only iStart leaves
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int INSTR_WIDTH = DEFAULT_INSTR_WIDTH,
  parameter int MAX_WORDS   = DEFAULT_MAX_WORDS
) (
  input logic             Clock,
  input logic             Reset,
  program_loader_if.slave bus
);

  localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

  loaderState_t           state;
  logic [7:0]             lenHi;
  logic [ADDR_WIDTH-1:0]  wordTarget;
  logic [ADDR_WIDTH-1:0]  wordCountNext;
  logic [15:0]            lenValue;
  logic                   byteXfer;
  logic                   dataByte;
  logic                   startSession;
  logic                   wordComplete;
  logic [INSTR_WIDTH-1:0] assembledWord;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]             checksum;
`endif

  assign byteXfer      = bus.iByteValid && bus.oByteReady;
  assign dataByte      = byteXfer && (state == DATA);
  assign startSession  = bus.iStart && ((state == IDLE) || (state == ERROR));
  assign lenValue      = {lenHi, bus.iByte};
  assign wordCountNext = bus.oWordCount + ADDR_WIDTH'(1);

  instr_byte_assembler #(.INSTR_WIDTH(INSTR_WIDTH)) assembler (
    .Clock        (Clock),
    .Reset        (Reset),
    .clear        (startSession),
    .byteEn       (dataByte),
    .byteIn       (bus.iByte),
    .wordComplete (wordComplete),
    .word         (assembledWord)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state                 <= IDLE;
      lenHi                 <= '0;
      wordTarget            <= '0;
      bus.oByteReady        <= 1'b0;
      bus.oInstrWriteEnable <= 1'b0;
      bus.oInstrAddress     <= '0;
      bus.oInstrData        <= '0;
      bus.oCpuReset         <= 1'b0;
      bus.oDone             <= 1'b0;
      bus.oError            <= 1'b0;
      bus.oWordCount        <= '0;
`ifdef LOADER_CHECKSUM_EN
      checksum              <= '0;
`endif
    end else begin
      bus.oInstrWriteEnable <= 1'b0;
      bus.oDone             <= 1'b0;
      if (startSession) begin
        state          <= LEN_HI;
        bus.oByteReady <= 1'b1;
        bus.oCpuReset  <= 1'b1;
        bus.oWordCount <= '0;
        bus.oError     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
        checksum       <= '0;
`endif
      end else begin
        case (state)
          LEN_HI: begin
            if (byteXfer) begin
              lenHi <= bus.iByte;
              state <= LEN_LO;
            end
          end
          LEN_LO: begin
            if (byteXfer) begin
              if (lengthInRange(lenValue, MAX_LEN)) begin
                state      <= DATA;
                wordTarget <= ADDR_WIDTH'(lenValue);
              end else begin
                state          <= ERROR;
                bus.oByteReady <= 1'b0;
                bus.oError     <= 1'b1;
              end
            end
          end
          DATA: begin
            if (byteXfer) begin
`ifdef LOADER_CHECKSUM_EN
              checksum <= checksum ^ bus.iByte;
`endif
              if (wordComplete) begin
                state                 <= WRITE;
                bus.oByteReady        <= 1'b0;
                bus.oInstrWriteEnable <= 1'b1;
                bus.oInstrAddress     <= bus.oWordCount;
                bus.oInstrData        <= assembledWord;
              end
            end
          end
          WRITE: begin
            bus.oWordCount <= wordCountNext;
            if (wordCountNext == wordTarget) begin
`ifdef LOADER_CHECKSUM_EN
              state          <= CHECK;
              bus.oByteReady <= 1'b1;
`else
              state          <= DONE;
              bus.oDone      <= 1'b1;
`endif
            end else begin
              state          <= DATA;
              bus.oByteReady <= 1'b1;
            end
          end
`ifdef LOADER_CHECKSUM_EN
          CHECK: begin
            if (byteXfer) begin
              bus.oByteReady <= 1'b0;
              if (bus.iByte == checksum) begin
                state     <= DONE;
                bus.oDone <= 1'b1;
              end else begin
                state      <= ERROR;
                bus.oError <= 1'b1;
              end
            end
          end
`endif
          DONE: begin
            state         <= IDLE;
            bus.oCpuReset <= 1'b0;
          end
          default: begin
            // IDLE and ERROR only leave through startSession.
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  localparam int AW   = 16;
  localparam int IW   = 28;
  localparam int MAXW = 256;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic Clock = 1'b0;
  logic Reset;

  program_loader_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) bus ();

  program_loader #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .MAX_WORDS(MAXW)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  int total = 0;
  int bad   = 0;

  // write/done monitor, only ever appended to; sessions take snapshots
  int logAddr[$];
  int logData[$];
  int doneCount = 0;

  always @(negedge Clock) begin
    if (!Reset) begin
      if (bus.oInstrWriteEnable) begin
        logAddr.push_back(int'(bus.oInstrAddress));
        logData.push_back(int'(bus.oInstrData));
      end
      if (bus.oDone) doneCount++;
    end
  end

  // stimulus and reference model state
  int           words[$];
  byte unsigned stream[$];
  int           mData[$];
  int           mConsumed;
  bit           mDone;
  bit           mErr;

  typedef struct {
    int len;
    int nWords;
    bit stall;
    int expDone;
    int expErr;
    int expCount;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic randomWords(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back(int'($urandom_range(0, 32'h0FFF_FFFF)));
  endtask

  // Length bytes, then each word as 4 big-endian bytes with a junk top nibble
  // in b0, then (checksum build) the XOR of all data bytes, optionally corrupted.
  task automatic buildStream(input int len, input bit flip);
    byte unsigned cs;
    byte unsigned b0, b1, b2, b3;
    cs = 8'h00;
    stream.delete();
    stream.push_back(8'(len >> 8));
    stream.push_back(8'(len));
    foreach (words[i]) begin
      b0 = {4'($urandom_range(0, 15)), 4'(words[i] >> 24)};
      b1 = 8'(words[i] >> 16);
      b2 = 8'(words[i] >> 8);
      b3 = 8'(words[i]);
      stream.push_back(b0);
      stream.push_back(b1);
      stream.push_back(b2);
      stream.push_back(b3);
      cs = cs ^ b0 ^ b1 ^ b2 ^ b3;
    end
    if (CSUM_EN) stream.push_back(cs ^ {7'd0, flip});
  endtask

  // Interprets the stream by the format rules: how many bytes the loader
  // takes, which words land in memory, and how the session ends.
  task automatic runModel();
    int n, p, w;
    byte unsigned cs;
    mData.delete();
    mDone = 0;
    mErr  = 0;
    n = int'(stream[0]) * 256 + int'(stream[1]);
    mConsumed = 2;
    if (n == 0 || n > MAXW) begin
      mErr = 1;
      return;
    end
    p  = 2;
    cs = 8'h00;
    for (int k = 0; k < n; k++) begin
      w = (int'(stream[p]) % 16) * (1 << 24) + int'(stream[p+1]) * 65536
          + int'(stream[p+2]) * 256 + int'(stream[p+3]);
      cs = cs ^ stream[p] ^ stream[p+1] ^ stream[p+2] ^ stream[p+3];
      mData.push_back(w);
      p += 4;
    end
    mConsumed = p;
    if (CSUM_EN) begin
      mConsumed = p + 1;
      if (stream[p] == cs) mDone = 1;
      else mErr = 1;
    end else begin
      mDone = 1;
    end
  endtask

  task automatic startPulse();
    bus.iStart = 1'b1;
    @(posedge Clock); #1;
    bus.iStart = 1'b0;
  endtask

  task automatic sendByte(input byte unsigned b, input bit stall);
    int guard;
    bit acc;
    guard = 0;
    if (stall) begin
      while ($urandom_range(0, 1) == 0 && guard < 8) begin
        bus.iByteValid = 1'b0;
        bus.iByte      = 8'($urandom);
        @(posedge Clock); #1;
        guard++;
      end
    end
    bus.iByte      = b;
    bus.iByteValid = 1'b1;
    acc   = 1'b0;
    guard = 0;
    while (!acc && guard < 40) begin
      acc = bus.oByteReady;
      @(posedge Clock); #1;
      guard++;
    end
    bus.iByteValid = 1'b0;
    check("byteAccepted", acc, 1);
  endtask

  task automatic runSession(input string tag, input bit stall, input int expDone,
                            input int expErr, input int expCount);
    int a0, d0, nw;
    runModel();
    a0 = logAddr.size();
    d0 = doneCount;
    startPulse();
    check({tag, ".startReady"}, bus.oByteReady, 1);
    check({tag, ".startCpuReset"}, bus.oCpuReset, 1);
    check({tag, ".startErrorClear"}, bus.oError, 0);
    check({tag, ".startCount"}, bus.oWordCount, 0);
    for (int i = 0; i < mConsumed; i++) sendByte(stream[i], stall);
    repeat (6) @(posedge Clock);
    #1;
    nw = logAddr.size() - a0;
    check({tag, ".writes"}, nw, expCount);
    for (int i = 0; i < nw && i < mData.size(); i++) begin
      check({tag, ".addr"}, logAddr[a0+i], i);
      check({tag, ".data"}, logData[a0+i], mData[i]);
    end
    check({tag, ".done"}, doneCount - d0, expDone);
    check({tag, ".error"}, bus.oError, expErr);
    check({tag, ".cpuReset"}, bus.oCpuReset, expErr);
    check({tag, ".wordCount"}, bus.oWordCount, expCount);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, d0, s0;
    int saveData[$];

    bus.iStart     = 1'b0;
    bus.iByte      = 8'h00;
    bus.iByteValid = 1'b0;
    Reset          = 1'b1;
    #12;
    check("rst.ready", bus.oByteReady, 0);
    check("rst.we", bus.oInstrWriteEnable, 0);
    check("rst.addr", bus.oInstrAddress, 0);
    check("rst.data", bus.oInstrData, 0);
    check("rst.cpuReset", bus.oCpuReset, 0);
    check("rst.done", bus.oDone, 0);
    check("rst.error", bus.oError, 0);
    check("rst.count", bus.oWordCount, 0);
    @(posedge Clock); #1;
    Reset = 1'b0;
    @(posedge Clock); #1;

    // Hand sequence: the two fixed words with exact end-of-load timing.
    words.delete();
    words.push_back(28'h100_0005);
    words.push_back(28'hABC_DEF0);
    buildStream(2, 1'b0);
    runModel();
    a0 = logAddr.size();
    d0 = doneCount;
    startPulse();
    for (int i = 0; i < 10; i++) sendByte(stream[i], 1'b0);
    check("fixed.lastWe", bus.oInstrWriteEnable, 1);
    check("fixed.lastAddr", bus.oInstrAddress, 1);
    check("fixed.lastData", bus.oInstrData, 28'hABC_DEF0);
    check("fixed.lastCpuReset", bus.oCpuReset, 1);
    if (CSUM_EN) sendByte(stream[10], 1'b0);
    else begin
      @(posedge Clock); #1;
    end
    check("fixed.donePulse", bus.oDone, 1);
    check("fixed.doneCpuReset", bus.oCpuReset, 1);
    check("fixed.doneCount", bus.oWordCount, 2);
    @(posedge Clock); #1;
    check("fixed.doneFalls", bus.oDone, 0);
    check("fixed.cpuResetFalls", bus.oCpuReset, 0);
    check("fixed.firstAddr", logAddr[a0], 0);
    check("fixed.firstData", logData[a0], 28'h100_0005);
    check("fixed.secondAddr", logAddr[a0+1], 1);
    check("fixed.secondData", logData[a0+1], 28'hABC_DEF0);
    check("fixed.doneOnce", doneCount - d0, 1);

    // Table-driven sessions, random data checked against the model.
    vecs = '{
      '{2,     2,   0, 1, 0, 2},
      '{0,     0,   0, 0, 1, 0},
      '{1,     1,   0, 1, 0, 1},
      '{257,   0,   0, 0, 1, 0},
      '{256,   256, 0, 1, 0, 256},
      '{3,     3,   1, 1, 0, 3},
      '{65535, 0,   0, 0, 1, 0}
    };
    for (int v = 0; v < 7; v++) begin
      a0 = logAddr.size();
      randomWords(vecs[v].nWords);
      buildStream(vecs[v].len, 1'b0);
      runSession($sformatf("vec%0d", v), vecs[v].stall, vecs[v].expDone,
                 vecs[v].expErr, vecs[v].expCount);
      if (vecs[v].len == 256) check("max.lastAddr", logAddr[logAddr.size()-1], 255);
    end

    // ERROR holds with the core in reset until a new start.
    words.delete();
    buildStream(0, 1'b0);
    runSession("zeroLen", 1'b0, 0, 1, 0);
    repeat (5) @(posedge Clock);
    #1;
    check("errHold.error", bus.oError, 1);
    check("errHold.cpuReset", bus.oCpuReset, 1);
    check("errHold.ready", bus.oByteReady, 0);
    randomWords(1);
    buildStream(1, 1'b0);
    runSession("afterErr", 1'b0, 1, 0, 1);

    // Same 3-word stream with and without stalls gives identical writes.
    randomWords(3);
    buildStream(3, 1'b0);
    s0 = logAddr.size();
    runSession("noStall", 1'b0, 1, 0, 3);
    saveData.delete();
    for (int i = s0; i < logData.size(); i++) saveData.push_back(logData[i]);
    s0 = logAddr.size();
    runSession("stall", 1'b1, 1, 0, 3);
    for (int i = 0; i < saveData.size() && s0 + i < logData.size(); i++)
      check("stallMatch", logData[s0+i], saveData[i]);

`ifdef LOADER_CHECKSUM_EN
    randomWords(2);
    buildStream(2, 1'b1);
    runSession("badCsum", 1'b0, 0, 1, 2);
`endif

    // Reset while the 3rd byte of word 1 is on the bus.
    randomWords(2);
    buildStream(2, 1'b0);
    startPulse();
    for (int i = 0; i < 8; i++) sendByte(stream[i], 1'b0);
    bus.iByte      = stream[8];
    bus.iByteValid = 1'b1;
    #3;
    Reset = 1'b1;
    #1;
    check("midRst.ready", bus.oByteReady, 0);
    check("midRst.we", bus.oInstrWriteEnable, 0);
    check("midRst.addr", bus.oInstrAddress, 0);
    check("midRst.data", bus.oInstrData, 0);
    check("midRst.cpuReset", bus.oCpuReset, 0);
    check("midRst.done", bus.oDone, 0);
    check("midRst.error", bus.oError, 0);
    check("midRst.count", bus.oWordCount, 0);
    bus.iByteValid = 1'b0;
    @(posedge Clock); #1;
    Reset = 1'b0;
    @(posedge Clock); #1;
    randomWords(2);
    buildStream(2, 1'b0);
    runSession("afterRst", 1'b0, 1, 0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
